// File: rtl/age_issue_sched.sv
// Oldest-first issue scheduler: a small queue of entries, each waiting on one source tag,
// woken by a tag broadcast and issued in age order through a valid/ready port.
module age_issue_sched #(
  parameter int NumEntries = 8,
  parameter int DataWidth  = 32,
  parameter int TagWidth   = 4,
  localparam int CntWidth  = $clog2(NumEntries + 1),
  localparam int IdxWidth  = $clog2(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 enq_valid_i,
  output logic                 enq_ready_o,
  input  logic [DataWidth-1:0] enq_data_i,
  input  logic                 enq_src_rdy_i,
  input  logic [TagWidth-1:0]  enq_src_tag_i,
  input  logic                 wake_valid_i,
  input  logic [TagWidth-1:0]  wake_tag_i,
  output logic                 issue_valid_o,
  input  logic                 issue_ready_i,
  output logic [DataWidth-1:0] issue_data_o,
  output logic [IdxWidth-1:0]  issue_idx_o,
  output logic [CntWidth-1:0]  count_o
);

  logic [NumEntries-1:0]                 valid_q;
  logic [NumEntries-1:0]                 src_rdy_q;
  logic [TagWidth-1:0]                   src_tag_q [NumEntries];
  logic [DataWidth-1:0]                  data_q    [NumEntries];
  // older_q[i][j] = 1 means entry i was allocated before entry j.
  logic [NumEntries-1:0][NumEntries-1:0] older_q;
  logic [CntWidth-1:0]                   count_q;

  logic [NumEntries-1:0] cand;
  logic [NumEntries-1:0] sel;
  logic [NumEntries-1:0] enq_onehot;
  logic [IdxWidth-1:0]   free_idx;
  logic                  enq_fire;
  logic                  issue_fire;
  logic                  enq_src_rdy;

  assign enq_ready_o   = (count_q != CntWidth'(NumEntries));
  assign count_o       = count_q;
  assign cand          = valid_q & src_rdy_q;
  assign issue_valid_o = |cand;
  assign enq_fire      = enq_valid_i & enq_ready_o & ~flush_i;
  assign issue_fire    = issue_valid_o & issue_ready_i;
  assign enq_src_rdy   = enq_src_rdy_i | (wake_valid_i & (wake_tag_i == enq_src_tag_i));
  assign enq_onehot    = NumEntries'(1) << free_idx;

  // Descending scan so the lowest-index free slot is the one left standing.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    free_idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxWidth'(i);
    end
  end

  // An entry wins only if it is older than every other candidate; at most one can.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NumEntries; i++) begin
      // NOTE: blocking assignments here build the AND chain in order within one evaluation.
      sel[i] = cand[i];
      for (int j = 0; j < NumEntries; j++) begin
        if (j != i) sel[i] = sel[i] & (~cand[j] | older_q[i][j]);
      end
    end
  end

  // AND-OR mux on the one-hot select, so zero select yields zero outputs.
  always_comb begin
    issue_data_o = '0;
    issue_idx_o  = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (sel[i]) begin
        issue_data_o = issue_data_o | data_q[i];
        issue_idx_o  = issue_idx_o | IdxWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid_q   <= '0;
      src_rdy_q <= '0;
      older_q   <= '0;
      count_q   <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        if (valid_q[i] && !src_rdy_q[i] && wake_valid_i && (src_tag_q[i] == wake_tag_i))
          src_rdy_q[i] <= 1'b1;
      end
      valid_q <= (valid_q & ~(issue_fire ? sel : '0)) | (enq_fire ? enq_onehot : '0);
      if (enq_fire) begin
        src_rdy_q[free_idx] <= enq_src_rdy;
        for (int j = 0; j < NumEntries; j++) begin
          older_q[free_idx][j] <= 1'b0;
          older_q[j][free_idx] <= (IdxWidth'(j) != free_idx);
        end
      end
      unique case ({enq_fire, issue_fire})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; it is only observable behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      data_q[free_idx]    <= enq_data_i;
      src_tag_q[free_idx] <= enq_src_tag_i;
    end
  end

`ifndef SYNTHESIS
  a_sel_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(sel));
  a_enq_free:    assert property (@(posedge clk_i) disable iff (rst_i) enq_fire |-> !valid_q[free_idx]);
  a_count_pop:   assert property (@(posedge clk_i) disable iff (rst_i)
                                  CntWidth'($countones(valid_q)) == count_q);
`endif

endmodule

// File: tb/tb_age_issue_sched.sv
// Directed bench for age_issue_sched: expected issues go into a scoreboard queue as stimulus
// is driven and are popped and compared whenever the issue handshake fires.
module tb_age_issue_sched;

  localparam int NumEntries = 8;
  localparam int DataWidth  = 32;
  localparam int TagWidth   = 4;
  localparam int CntWidth   = $clog2(NumEntries + 1);
  localparam int IdxWidth   = $clog2(NumEntries);

  typedef struct {
    logic [DataWidth-1:0] data;
    logic [IdxWidth-1:0]  idx;
  } exp_t;

  logic                 clk_i;
  logic                 rst_i;
  logic                 flush_i;
  logic                 enq_valid_i;
  logic                 enq_ready_o;
  logic [DataWidth-1:0] enq_data_i;
  logic                 enq_src_rdy_i;
  logic [TagWidth-1:0]  enq_src_tag_i;
  logic                 wake_valid_i;
  logic [TagWidth-1:0]  wake_tag_i;
  logic                 issue_valid_o;
  logic                 issue_ready_i;
  logic [DataWidth-1:0] issue_data_o;
  logic [IdxWidth-1:0]  issue_idx_o;
  logic [CntWidth-1:0]  count_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  age_issue_sched #(
    .NumEntries(NumEntries),
    .DataWidth (DataWidth),
    .TagWidth  (TagWidth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .enq_valid_i  (enq_valid_i),
    .enq_ready_o  (enq_ready_o),
    .enq_data_i   (enq_data_i),
    .enq_src_rdy_i(enq_src_rdy_i),
    .enq_src_tag_i(enq_src_tag_i),
    .wake_valid_i (wake_valid_i),
    .wake_tag_i   (wake_tag_i),
    .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i),
    .issue_data_o (issue_data_o),
    .issue_idx_o  (issue_idx_o),
    .count_o      (count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    flush_i       = 1'b0;
    enq_valid_i   = 1'b0;
    enq_data_i    = '0;
    enq_src_rdy_i = 1'b0;
    enq_src_tag_i = '0;
    wake_valid_i  = 1'b0;
    wake_tag_i    = '0;
  endtask

  task automatic drive_enq(input logic [DataWidth-1:0] data, input logic rdy,
                           input logic [TagWidth-1:0] tag);
    enq_valid_i   = 1'b1;
    enq_data_i    = data;
    enq_src_rdy_i = rdy;
    enq_src_tag_i = tag;
  endtask

  task automatic drive_wake(input logic [TagWidth-1:0] tag);
    wake_valid_i = 1'b1;
    wake_tag_i   = tag;
  endtask

  // Called at a falling edge with inputs set: checks any issue handshake, crosses one rising
  // edge, and returns at the next falling edge with single-cycle pulses cleared.
  task automatic tick();
    exp_t e;
    #1;
    if (issue_valid_o === 1'b1 && issue_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        check("issue_unexpected", 64'(issue_data_o), 64'hDEAD_0000);
      end else begin
        e = sb.pop_front();
        check("issue_data", 64'(issue_data_o), 64'(e.data));
        check("issue_idx", 64'(issue_idx_o), 64'(e.idx));
      end
    end
    @(negedge clk_i);
    clear_pulses();
  endtask

  initial begin
    clear_pulses();
    issue_ready_i = 1'b0;
    rst_i         = 1'b1;
    #1;
    check("rst_count", 64'(count_o), 0);
    check("rst_issue_valid", 64'(issue_valid_o), 0);
    check("rst_issue_data", 64'(issue_data_o), 0);
    check("rst_issue_idx", 64'(issue_idx_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_enq_ready", 64'(enq_ready_o), 1);

    // In-order issue of three ready entries.
    drive_enq(32'hA, 1'b1, 4'h0); sb.push_back('{32'hA, 3'd0}); tick();
    check("fifo_count1", 64'(count_o), 1);
    drive_enq(32'hB, 1'b1, 4'h0); sb.push_back('{32'hB, 3'd1}); tick();
    check("fifo_count2", 64'(count_o), 2);
    drive_enq(32'hC, 1'b1, 4'h0); sb.push_back('{32'hC, 3'd2}); tick();
    check("fifo_count3", 64'(count_o), 3);
    issue_ready_i = 1'b1;
    tick(); check("fifo_drain2", 64'(count_o), 2);
    tick(); check("fifo_drain1", 64'(count_o), 1);
    tick(); check("fifo_drain0", 64'(count_o), 0);
    check("fifo_empty_valid", 64'(issue_valid_o), 0);

    // Younger ready entry bypasses older waiting one; wakeup-to-issue latency.
    issue_ready_i = 1'b0;
    drive_enq(32'h11, 1'b0, 4'h3); tick();
    drive_enq(32'h22, 1'b1, 4'h0); sb.push_back('{32'h22, 3'd1}); tick();
    issue_ready_i = 1'b1;
    tick();
    check("dep_blocked", 64'(issue_valid_o), 0);
    drive_wake(4'h3); sb.push_back('{32'h11, 3'd0});
    check("wake_cycle_valid", 64'(issue_valid_o), 0);
    tick();
    check("wake_next_valid", 64'(issue_valid_o), 1);
    tick();
    check("dep_drained", 64'(count_o), 0);

    // Full queue, freed slot not reusable in the issue cycle.
    issue_ready_i = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      drive_enq(32'h100 + 32'(i), 1'b0, TagWidth'(i)); tick();
    end
    check("full_count", 64'(count_o), 8);
    check("full_enq_ready", 64'(enq_ready_o), 0);
    drive_enq(32'h1FF, 1'b1, 4'h0); tick();
    check("full_drop_count", 64'(count_o), 8);
    drive_wake(4'h5); tick();
    check("full_wake_idx", 64'(issue_idx_o), 5);
    issue_ready_i = 1'b1;
    drive_enq(32'h200, 1'b0, 4'h9); sb.push_back('{32'h105, 3'd5});
    check("full_issue_enq_ready", 64'(enq_ready_o), 0);
    tick();
    check("after_issue_count", 64'(count_o), 7);
    check("after_issue_enq_ready", 64'(enq_ready_o), 1);
    issue_ready_i = 1'b0;
    drive_enq(32'h200, 1'b0, 4'h9); tick();
    drive_wake(4'h9); tick();
    sb.push_back('{32'h200, 3'd5});
    issue_ready_i = 1'b1;
    tick();
    check("refill_count", 64'(count_o), 7);

    // Out-of-order free: new entry reuses slot 2 but is youngest.
    issue_ready_i = 1'b0;
    drive_wake(4'h2); tick();
    drive_wake(4'h6); tick();
    sb.push_back('{32'h102, 3'd2});
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    drive_enq(32'h300, 1'b1, 4'h0); tick();
    drive_wake(4'h0); tick();
    check("ooo_oldest_idx", 64'(issue_idx_o), 0);
    sb.push_back('{32'h100, 3'd0});
    sb.push_back('{32'h106, 3'd6});
    sb.push_back('{32'h300, 3'd2});
    issue_ready_i = 1'b1;
    tick(); tick(); tick();
    check("ooo_count", 64'(count_o), 4);

    // Same-cycle wakeup bypass on enqueue.
    issue_ready_i = 1'b0;
    drive_enq(32'h400, 1'b0, 4'h5); drive_wake(4'h5); tick();
    check("bypass_valid", 64'(issue_valid_o), 1);
    check("bypass_data", 64'(issue_data_o), 32'h400);
    sb.push_back('{32'h400, 3'd0});
    issue_ready_i = 1'b1;
    tick();
    check("bypass_count", 64'(count_o), 4);

    // Flush beats a simultaneous enqueue; a same-cycle issue is still consumed.
    issue_ready_i = 1'b0;
    drive_enq(32'h500, 1'b1, 4'h0); tick();
    check("preflush_count", 64'(count_o), 5);
    flush_i       = 1'b1;
    issue_ready_i = 1'b1;
    drive_enq(32'h600, 1'b1, 4'h0);
    sb.push_back('{32'h500, 3'd0});
    tick();
    check("flush_count", 64'(count_o), 0);
    check("flush_issue_valid", 64'(issue_valid_o), 0);
    tick();
    check("flush_enq_dropped", 64'(count_o), 0);

    // Asynchronous reset mid-stream.
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(32'h700 + 32'(i), 1'b1, 4'h0); tick();
    end
    check("prereset_count", 64'(count_o), 3);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_count", 64'(count_o), 0);
    check("async_rst_valid", 64'(issue_valid_o), 0);
    check("async_rst_data", 64'(issue_data_o), 0);
    check("async_rst_idx", 64'(issue_idx_o), 0);
    check("async_rst_enq_ready", 64'(enq_ready_o), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_enq(32'h800, 1'b1, 4'h0); sb.push_back('{32'h800, 3'd0}); tick();
    issue_ready_i = 1'b1;
    tick();
    check("post_reset_count", 64'(count_o), 0);

    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
